// File: rtl/serdesphy_csr_bank_if.sv
// Register-access bus between a CSR master and the SerDes PHY CSR bank.
// It carries the write port, the read port and the one-cycle responses.
`timescale 1ns/1ps
interface serdesphy_csr_bank_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              addr_err;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_ack, rd_data, rd_valid, addr_err
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ack, rd_data, rd_valid, addr_err
  );
endinterface

// File: rtl/serdesphy_csr_bank.sv
// SerDes PHY CSR bank: control writes land in shadows and go live together on COMMIT.
// Status bits are either sticky W1C (feeding irq through IRQ_MASK) or live read-only.
`timescale 1ns/1ps
module serdesphy_csr_bank #(
  parameter int unsigned                  NUM_CTRL    = 8,
  parameter int unsigned                  NUM_STS     = 2,
  parameter int unsigned                  DATA_W      = 8,
  parameter int unsigned                  ADDR_W      = 5,
  parameter logic [NUM_CTRL*DATA_W-1:0]   CTRL_RST    = '0,
  parameter logic [NUM_STS*DATA_W-1:0]    STICKY_MASK = '1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  serdesphy_csr_bank_if.slave         bus,
  output logic [NUM_CTRL*DATA_W-1:0]  ctrl_out,
  input  logic [NUM_STS*DATA_W-1:0]   status_in,
  output logic                        commit_done,
  output logic                        irq
);

  localparam int unsigned       NUM_MAPPED  = NUM_CTRL + NUM_STS;
  localparam logic [ADDR_W-1:0] COMMIT_ADDR = '1;
  localparam logic [ADDR_W-1:0] MASK_ADDR   = {{(ADDR_W-1){1'b1}}, 1'b0};

  // The two top addresses are COMMIT and IRQ_MASK; the hole below them is unmapped.
  function automatic logic is_unmapped(input logic [ADDR_W-1:0] addr);
    return (32'(addr) >= NUM_MAPPED) && (addr != COMMIT_ADDR) && (addr != MASK_ADDR);
  endfunction

  logic [DATA_W-1:0]          shadow_q   [NUM_CTRL];
  logic [DATA_W-1:0]          shadow_d   [NUM_CTRL];
  logic [NUM_CTRL*DATA_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0]          sticky_q   [NUM_STS];
  logic [DATA_W-1:0]          sticky_d   [NUM_STS];
  logic [DATA_W-1:0]          w1c_clr    [NUM_STS];
  logic [DATA_W-1:0]          sts_view   [NUM_STS];
  logic [DATA_W-1:0]          irq_mask_q, irq_mask_d;
  logic [DATA_W-1:0]          rd_data_q, rd_data_d;
  logic                       irq_q, irq_d;
  logic                       wr_ack_q, wr_ack_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       addr_err_q, addr_err_d;
  logic                       commit_done_q, commit_done_d;
  logic                       commit_hit;

  always_comb begin
    shadow_d   = shadow_q;
    irq_mask_d = irq_mask_q;
    commit_hit = bus.wr_req && (bus.wr_addr == COMMIT_ADDR) && bus.wr_data[0];
    for (int unsigned i = 0; i < NUM_CTRL; i++) begin
      if (bus.wr_req && (bus.wr_addr == ADDR_W'(i))) begin
        shadow_d[i] = bus.wr_data;
      end
    end
    if (bus.wr_req && (bus.wr_addr == MASK_ADDR)) begin
      irq_mask_d = bus.wr_data;
    end
  end

  // Commit copies the pre-edge shadows, so a control write in the previous cycle is included.
  always_comb begin
    ctrl_d = ctrl_q;
    if (commit_hit) begin
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        ctrl_d[i*DATA_W +: DATA_W] = shadow_q[i];
      end
    end
  end

  // Set is OR-ed in after the W1C clear so a coincident set wins; live bits never store.
  always_comb begin
    for (int unsigned s = 0; s < NUM_STS; s++) begin
      w1c_clr[s] = '0;
      if (bus.wr_req && (bus.wr_addr == ADDR_W'(NUM_CTRL + s))) begin
        w1c_clr[s] = bus.wr_data;
      end
      sticky_d[s] = ((sticky_q[s] & ~w1c_clr[s]) | status_in[s*DATA_W +: DATA_W])
                    & STICKY_MASK[s*DATA_W +: DATA_W];
      sts_view[s] = sticky_q[s]
                    | (status_in[s*DATA_W +: DATA_W] & ~STICKY_MASK[s*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    irq_d = 1'b0;
    for (int unsigned s = 0; s < NUM_STS; s++) begin
      irq_d = irq_d | (|(sticky_q[s] & irq_mask_q));
    end
  end

  // Reads see pre-edge state, giving read-before-write on a same-address collision.
  always_comb begin
    rd_data_d = '0;
    if (bus.rd_req) begin
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        if (bus.rd_addr == ADDR_W'(i)) begin
          rd_data_d = shadow_q[i];
        end
      end
      for (int unsigned s = 0; s < NUM_STS; s++) begin
        if (bus.rd_addr == ADDR_W'(NUM_CTRL + s)) begin
          rd_data_d = sts_view[s];
        end
      end
      if (bus.rd_addr == MASK_ADDR) begin
        rd_data_d = irq_mask_q;
      end
    end
  end

  always_comb begin
    wr_ack_d      = bus.wr_req;
    rd_valid_d    = bus.rd_req;
    commit_done_d = commit_hit;
    addr_err_d    = (bus.wr_req && is_unmapped(bus.wr_addr))
                  || (bus.rd_req && is_unmapped(bus.rd_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        shadow_q[i] <= CTRL_RST[i*DATA_W +: DATA_W];
      end
      for (int unsigned s = 0; s < NUM_STS; s++) begin
        sticky_q[s] <= '0;
      end
      ctrl_q        <= CTRL_RST;
      irq_mask_q    <= '0;
      rd_data_q     <= '0;
      irq_q         <= 1'b0;
      wr_ack_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
      addr_err_q    <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CTRL; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      for (int unsigned s = 0; s < NUM_STS; s++) begin
        sticky_q[s] <= sticky_d[s];
      end
      ctrl_q        <= ctrl_d;
      irq_mask_q    <= irq_mask_d;
      rd_data_q     <= rd_data_d;
      irq_q         <= irq_d;
      wr_ack_q      <= wr_ack_d;
      rd_valid_q    <= rd_valid_d;
      addr_err_q    <= addr_err_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign bus.wr_ack   = wr_ack_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.addr_err = addr_err_q;
  assign ctrl_out     = ctrl_q;
  assign commit_done  = commit_done_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_serdesphy_csr_bank.sv
// Scoreboard bench for serdesphy_csr_bank: stimulus pushes expected responses from an
// array-based register model; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_serdesphy_csr_bank;
  localparam int NC = 8;
  localparam int NS = 2;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam logic [NC*DW-1:0] CRST  = 64'h8877_6655_4400_2211;
  localparam logic [NS*DW-1:0] SMASK = 16'h0FFF;

  typedef struct {
    int         tag;
    logic       ack;
    logic       valid;
    logic [7:0] data;
    logic       err;
    logic       commit;
  } exp_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [NC*DW-1:0] ctrl_out;
  logic [NS*DW-1:0] status_in;
  logic             commit_done;
  logic             irq;

  serdesphy_csr_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  serdesphy_csr_bank #(
    .NUM_CTRL(NC), .NUM_STS(NS), .DATA_W(DW), .ADDR_W(AW),
    .CTRL_RST(CRST), .STICKY_MASK(SMASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ctrl_out(ctrl_out),
    .status_in(status_in), .commit_done(commit_done), .irq(irq)
  );

  always #5 clk = ~clk;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [7:0]       shadow_m [NC];
  logic [7:0]       ctrl_m   [NC];
  logic [7:0]       sticky_m [NS];
  logic [7:0]       mask_m;
  logic             irq_m;
  logic [NC*DW-1:0] ctrl_now;
  logic             irq_now;

  logic       r_wr, r_rd;
  int         r_wa, r_ra;
  logic [7:0] r_wd;
  logic [15:0] r_st;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NC*DW-1:0] packCtrl();
    logic [NC*DW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = ctrl_m[i];
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NC; i++) begin
      shadow_m[i] = CRST[i*DW +: DW];
      ctrl_m[i]   = CRST[i*DW +: DW];
    end
    for (int s = 0; s < NS; s++) sticky_m[s] = 8'h00;
    mask_m   = 8'h00;
    irq_m    = 1'b0;
    ctrl_now = CRST;
    irq_now  = 1'b0;
  endtask

  function automatic logic isUnmapped(input int a);
    return (a >= NC + NS) && (a <= 29);
  endfunction

  function automatic logic [7:0] modelRead(input int a, input logic [15:0] sts);
    logic [7:0] m;
    if (a < NC) return shadow_m[a];
    if (a < NC + NS) begin
      m = SMASK[(a-NC)*DW +: DW];
      return sticky_m[a-NC] | (sts[(a-NC)*DW +: DW] & ~m);
    end
    if (a == 30) return mask_m;
    return 8'h00;
  endfunction

  function automatic int pickAddr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 5)  return int'($urandom_range(0, NC-1));
    if (r < 7)  return NC + int'($urandom_range(0, NS-1));
    if (r == 7) return 30;
    if (r == 8) return 31;
    return int'($urandom_range(NC+NS, 29));
  endfunction

  // Drives one cycle of requests, predicts the responses, advances the model past the edge.
  task automatic applyStimulus(input logic wr, input int wa, input logic [7:0] wd,
                               input logic rd, input int ra, input logic [15:0] sts);
    exp_t       e;
    logic       any;
    logic [7:0] clr, m;
    bus.wr_req  = wr;
    bus.wr_addr = AW'(wa);
    bus.wr_data = wd;
    bus.rd_req  = rd;
    bus.rd_addr = AW'(ra);
    status_in   = sts;
    if (wr || rd) begin
      e.tag    = cyc;
      e.ack    = wr;
      e.valid  = rd;
      e.data   = rd ? modelRead(ra, sts) : 8'h00;
      e.err    = (wr && isUnmapped(wa)) || (rd && isUnmapped(ra));
      e.commit = wr && (wa == 31) && wd[0];
      exp_q.push_back(e);
    end
    any = 1'b0;
    for (int s = 0; s < NS; s++) any = any | (|(sticky_m[s] & mask_m));
    for (int s = 0; s < NS; s++) begin
      clr = (wr && wa == NC + s) ? wd : 8'h00;
      m   = SMASK[s*DW +: DW];
      sticky_m[s] = ((sticky_m[s] & ~clr) | sts[s*DW +: DW]) & m;
    end
    if (wr) begin
      if (wa == 31 && wd[0]) for (int i = 0; i < NC; i++) ctrl_m[i] = shadow_m[i];
      if (wa < NC) shadow_m[wa] = wd;
      if (wa == 30) mask_m = wd;
    end
    irq_m = any;
    @(posedge clk);
    #1;
    ctrl_now   = packCtrl();
    irq_now    = irq_m;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
  endtask

  task automatic idle(input logic [15:0] sts);
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 0, sts);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (exp_q.size() > 0 && exp_q[0].tag + 1 < cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL response_timeout: request of cycle %0d got no response by cycle %0d",
                   exp_q[0].tag, cyc);
          mon_e = exp_q.pop_front();
        end
        if (bus.wr_ack || bus.rd_valid || bus.addr_err || commit_done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_response: wr_ack=%b rd_valid=%b addr_err=%b commit_done=%b with nothing pending",
                     bus.wr_ack, bus.rd_valid, bus.addr_err, commit_done);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("latency", 64'(cyc), 64'(mon_e.tag + 1));
            checkOutput("wr_ack", 64'(bus.wr_ack), 64'(mon_e.ack));
            checkOutput("rd_valid", 64'(bus.rd_valid), 64'(mon_e.valid));
            checkOutput("rd_data", 64'(bus.rd_data), 64'(mon_e.data));
            checkOutput("addr_err", 64'(bus.addr_err), 64'(mon_e.err));
            checkOutput("commit_done", 64'(commit_done), 64'(mon_e.commit));
          end
        end
        if (!bus.rd_valid) checkOutput("rd_data_idle", 64'(bus.rd_data), 64'h0);
        checkOutput("ctrl_out", 64'(ctrl_out), 64'(ctrl_now));
        checkOutput("irq", 64'(irq), 64'(irq_now));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    status_in   = '0;
    modelReset();
    $display("[TB] starting serdesphy_csr_bank bench");
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctrl_out", 64'(ctrl_out), 64'(CRST));
    checkOutput("reset_irq", 64'(irq), 64'h0);
    checkOutput("reset_wr_ack", 64'(bus.wr_ack), 64'h0);
    checkOutput("reset_rd_valid", 64'(bus.rd_valid), 64'h0);
    checkOutput("reset_rd_data", 64'(bus.rd_data), 64'h0);
    checkOutput("reset_addr_err", 64'(bus.addr_err), 64'h0);
    checkOutput("reset_commit_done", 64'(commit_done), 64'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Shadow write, readback, commit
    applyStimulus(1'b1, 2, 8'h5A, 1'b0, 0, 16'h0);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 2, 16'h0);
    checkOutput("shadow_readback", 64'(bus.rd_data), 64'h5A);
    checkOutput("ctrl2_before_commit", 64'(ctrl_out[2*DW +: DW]), 64'h00);
    applyStimulus(1'b1, 31, 8'h01, 1'b0, 0, 16'h0);
    checkOutput("commit_pulse", 64'(commit_done), 64'h1);
    checkOutput("ctrl2_after_commit", 64'(ctrl_out[2*DW +: DW]), 64'h5A);
    idle(16'h0);
    checkOutput("commit_pulse_end", 64'(commit_done), 64'h0);
    applyStimulus(1'b1, 2, 8'h11, 1'b0, 0, 16'h0);
    applyStimulus(1'b1, 31, 8'hFE, 1'b0, 0, 16'h0);
    checkOutput("commit_bit0_clear", 64'(ctrl_out[2*DW +: DW]), 64'h5A);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 31, 16'h0);
    checkOutput("commit_reads_zero", 64'(bus.rd_data), 64'h00);
    applyStimulus(1'b1, 4, 8'hC3, 1'b0, 0, 16'h0);
    applyStimulus(1'b1, 31, 8'h01, 1'b0, 0, 16'h0);
    checkOutput("back_to_back_commit", 64'(ctrl_out[4*DW +: DW]), 64'hC3);
    applyStimulus(1'b1, 2, 8'h77, 1'b1, 2, 16'h0);
    checkOutput("read_before_write", 64'(bus.rd_data), 64'h11);

    // Sticky status and W1C
    idle(16'h0008);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 8, 16'h0);
    checkOutput("sticky_set", 64'(bus.rd_data), 64'h08);
    applyStimulus(1'b1, 8, 8'h08, 1'b0, 0, 16'h0);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 8, 16'h0);
    checkOutput("sticky_w1c", 64'(bus.rd_data), 64'h00);
    applyStimulus(1'b1, 8, 8'h08, 1'b0, 0, 16'h0008);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 8, 16'h0);
    checkOutput("set_beats_clear", 64'(bus.rd_data), 64'h08);
    applyStimulus(1'b1, 8, 8'h08, 1'b0, 0, 16'h0);

    // Interrupt path
    applyStimulus(1'b1, 30, 8'h08, 1'b0, 0, 16'h0);
    idle(16'h0008);
    checkOutput("irq_lags_sticky", 64'(irq), 64'h0);
    idle(16'h0);
    checkOutput("irq_rise", 64'(irq), 64'h1);
    applyStimulus(1'b1, 8, 8'h08, 1'b0, 0, 16'h0);
    checkOutput("irq_hold_one", 64'(irq), 64'h1);
    idle(16'h0);
    checkOutput("irq_fall", 64'(irq), 64'h0);
    applyStimulus(1'b1, 30, 8'h00, 1'b0, 0, 16'h0);
    idle(16'h0008);
    idle(16'h0);
    idle(16'h0);
    checkOutput("irq_masked", 64'(irq), 64'h0);
    applyStimulus(1'b1, 8, 8'hFF, 1'b0, 0, 16'h0);

    // Live bits in the upper nibble of status register 1
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 9, 16'hA500);
    checkOutput("live_read", 64'(bus.rd_data), 64'hA0);
    applyStimulus(1'b1, 9, 8'hFF, 1'b1, 9, 16'h0);
    checkOutput("sticky_low_nibble", 64'(bus.rd_data), 64'h05);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 9, 16'h0);
    checkOutput("sts1_cleared", 64'(bus.rd_data), 64'h00);

    // Unmapped address
    applyStimulus(1'b1, 12, 8'hFF, 1'b0, 0, 16'h0);
    checkOutput("unmapped_wr_ack", 64'(bus.wr_ack), 64'h1);
    checkOutput("unmapped_wr_err", 64'(bus.addr_err), 64'h1);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 12, 16'h0);
    checkOutput("unmapped_rd_data", 64'(bus.rd_data), 64'h00);
    checkOutput("unmapped_rd_valid", 64'(bus.rd_valid), 64'h1);
    checkOutput("unmapped_rd_err", 64'(bus.addr_err), 64'h1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_rd = 1'($urandom_range(0, 1));
      r_wa = pickAddr();
      r_ra = pickAddr();
      r_wd = 8'($urandom);
      r_st = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'h0;
      applyStimulus(r_wr, r_wa, r_wd, r_rd, r_ra, r_st);
    end

    // Reset in the middle of a write, after a commit
    applyStimulus(1'b1, 0, 8'hEE, 1'b0, 0, 16'h0);
    applyStimulus(1'b1, 31, 8'h01, 1'b0, 0, 16'h0);
    idle(16'h0);
    idle(16'h0);
    checkOutput("ctrl0_committed", 64'(ctrl_out[0 +: DW]), 64'hEE);
    bus.wr_req  = 1'b1;
    bus.wr_addr = AW'(3);
    bus.wr_data = 8'h99;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_ctrl_out", 64'(ctrl_out), 64'(CRST));
    checkOutput("async_reset_irq", 64'(irq), 64'h0);
    checkOutput("async_reset_wr_ack", 64'(bus.wr_ack), 64'h0);
    bus.wr_req = 1'b0;
    exp_q.delete();
    modelReset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 3, 16'h0);
    checkOutput("discarded_write", 64'(bus.rd_data), 64'h44);
    idle(16'h0);
    idle(16'h0);
    idle(16'h0);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serdesphy_csr_bank.md
SERDESPHY_CSR_BANK -- requirements
Module: serdesphy_csr_bank

Interface
REQ-001 Parameter NUM_CTRL, default 8: number of shadowed control registers, at addresses 0..NUM_CTRL-1.
REQ-002 Parameter NUM_STS, default 2: number of status registers, at addresses NUM_CTRL..NUM_CTRL+NUM_STS-1.
REQ-003 Parameter DATA_W, default 8: register width in bits.
REQ-004 Parameter ADDR_W, default 5: address width; NUM_CTRL+NUM_STS SHALL be at most 2^ADDR_W-2.
REQ-005 Parameter CTRL_RST, default all zeros, NUM_CTRL*DATA_W bits: reset value of the control registers; register i occupies bits [i*DATA_W +: DATA_W].
REQ-006 Parameter STICKY_MASK, default all ones, NUM_STS*DATA_W bits: 1 = sticky W1C bit, 0 = live read-only bit.
REQ-007 clk  in  1  system clock (24 MHz).
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 wr_req  in  1  write request, sampled every cycle.
REQ-010 wr_addr  in  ADDR_W  write address.
REQ-011 wr_data  in  DATA_W  write data.
REQ-012 wr_ack  out  1  one-cycle acknowledge of an accepted write.
REQ-013 rd_req  in  1  read request.
REQ-014 rd_addr  in  ADDR_W  read address.
REQ-015 rd_data  out  DATA_W  read data, qualified by rd_valid.
REQ-016 rd_valid  out  1  one-cycle read-data strobe.
REQ-017 addr_err  out  1  one-cycle pulse on any access to an unmapped address.
REQ-018 ctrl_out  out  NUM_CTRL*DATA_W  active (committed) control values.
REQ-019 status_in  in  NUM_STS*DATA_W  raw status from the PHY blocks, already synchronous to clk.
REQ-020 commit_done  out  1  one-cycle pulse when a commit is applied.
REQ-021 irq  out  1  level interrupt, registered.

Function
REQ-022 Write latency: a write with wr_req=1 in cycle N SHALL update the target state at the cycle N clock edge and assert wr_ack in cycle N+1; wr_ack SHALL be asserted for every request, including unmapped addresses.
REQ-023 Read latency: a read with rd_req=1 in cycle N SHALL present rd_data with rd_valid=1 in cycle N+1; rd_data SHALL be 0 whenever rd_valid=0.
REQ-024 If a read and a write hit the same address in the same cycle, the read SHALL return the pre-write value.
REQ-025 A write to control address i SHALL update shadow[i] only; ctrl_out SHALL NOT change.
REQ-026 A read of control address i SHALL return shadow[i].
REQ-027 COMMIT is at address 2^ADDR_W-1: writing it with wr_data[0]=1 SHALL copy all shadows to ctrl_out atomically at the same edge and pulse commit_done in cycle N+1.
REQ-028 Writing COMMIT with wr_data[0]=0 SHALL have no effect; reading COMMIT SHALL return 0.
REQ-029 If a control write and a COMMIT write are in the same cycle, they SHALL be impossible (single write port); back-to-back writes (ctrl in N, COMMIT in N+1) SHALL commit the new shadow value.
REQ-030 IRQ_MASK is at address 2^ADDR_W-2: a DATA_W-bit read/write register; bit b SHALL enable bit b of every status register onto irq.
REQ-031 Status bits with STICKY_MASK=1 SHALL be set in any cycle where the corresponding status_in bit is 1, held until cleared, and cleared by writing 1 to that bit (W1C).
REQ-032 When a set and a W1C clear coincide on the same bit, set SHALL win.
REQ-033 Status bits with STICKY_MASK=0 SHALL read the live status_in value; writes to them SHALL be ignored.
REQ-034 irq SHALL equal, one cycle later, the OR over all status registers s and bits b of (sticky[s][b] & irq_mask[b]); live bits SHALL NOT contribute to irq.
REQ-035 Any access to an address in the range NUM_CTRL+NUM_STS..2^ADDR_W-3 SHALL pulse addr_err in cycle N+1.
REQ-036 A write to an unmapped address SHALL change no state; a read of an unmapped address SHALL return 0 with rd_valid=1.

Reset
REQ-037 On rst_n=0 the block SHALL immediately load shadow and ctrl_out with CTRL_RST, and clear the sticky bits, irq_mask, irq, wr_ack, rd_valid, rd_data, addr_err and commit_done.
REQ-038 A request in flight when reset asserts SHALL be discarded: no wr_ack and no rd_valid after release.
REQ-039 After release, the first request SHALL be accepted at the first rising edge with rst_n=1.

Verification
REQ-040 Write 0x5A to address 2, then read address 2 -> rd_data=0x5A in the following cycle; ctrl_out reg 2 stays 0x00 until COMMIT is written with 0x01, then ctrl_out reg 2 = 0x5A and commit_done pulses once.
REQ-041 Pulse status_in bit 3 of status reg 0 for one cycle -> a read returns 0x08 thereafter; write 0x08 to address 8 -> a read returns 0x00.
REQ-042 Hold status_in bit 3 high while writing 0x08 (W1C) to that register -> the bit stays 1.
REQ-043 Write irq_mask=0x08, then set sticky bit 3 -> irq rises one cycle after the sticky bit; W1C the bit -> irq falls next cycle; with irq_mask=0x00 -> irq stays 0.
REQ-044 Write to address 12 (defaults) -> wr_ack=1 and addr_err=1 in cycle N+1, no state change; a read of address 12 -> rd_data=0x00, rd_valid=1, addr_err=1.
REQ-045 Assert rst_n=0 mid-write after a commit -> ctrl_out returns to CTRL_RST asynchronously; no wr_ack after release.
